// File: rtl/hazard_ctrl.sv
// ID-stage hazard controller: load-use/RAW stalls, jump and branch-miss flushes,
// a data-memory wait freeze with timeout flag, a halt state and saturating counters.
module hazard_ctrl #(
    parameter int unsigned REG_ADDR_W         = 2,
    parameter int unsigned DATA_FORWARDING    = 1,
    parameter int unsigned RF_SELF_FORWARDING = 1,
    parameter int unsigned CNT_W              = 16,
    parameter int unsigned MAX_WAIT           = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  use_rs,
    input  logic                  use_rt,
    input  logic                  use_rs_at_id,
    input  logic                  is_jump_id,
    input  logic [REG_ADDR_W-1:0] rs_id,
    input  logic [REG_ADDR_W-1:0] rt_id,
    input  logic                  reg_write_ex,
    input  logic                  reg_write_mem,
    input  logic                  reg_write_wb,
    input  logic [REG_ADDR_W-1:0] write_reg_ex,
    input  logic [REG_ADDR_W-1:0] write_reg_mem,
    input  logic [REG_ADDR_W-1:0] write_reg_wb,
    input  logic                  d_mem_read_ex,
    input  logic                  d_mem_read_mem,
    input  logic                  d_mem_read_wb,
    input  logic [REG_ADDR_W-1:0] rt_ex,
    input  logic [REG_ADDR_W-1:0] rt_mem,
    input  logic [REG_ADDR_W-1:0] rt_wb,
    input  logic                  branch_miss,
    input  logic                  d_mem_req_mem,
    input  logic                  d_mem_ready,
    input  logic                  halt_wb,
    output logic                  pc_write,
    output logic                  ir_write,
    output logic                  bubblify,
    output logic                  flush_if,
    output logic                  freeze,
    output logic                  incr_num_inst,
    output logic                  halted,
    output logic                  mem_timeout,
    output logic [CNT_W-1:0]      num_inst,
    output logic [CNT_W-1:0]      num_stall,
    output logic [CNT_W-1:0]      num_flush
);

    localparam int unsigned WAIT_W  = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic        NO_FWD  = (DATA_FORWARDING == 0);
    localparam logic        NO_RFSF = (RF_SELF_FORWARDING == 0);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DWAIT = 2'd1,
        S_HALT  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0]  num_inst_q, num_inst_d;
    logic [CNT_W-1:0]  num_stall_q, num_stall_d;
    logic [CNT_W-1:0]  num_flush_q, num_flush_d;

    logic dwait_cond;
    logic rs_any;
    logic ex_rs, ex_rt, mem_rs, mem_rt, wb_rs, wb_rt;
    logic raw_ex, raw_mem, raw_wb;
    logic lu_ex, lu_mem, lu_wb;
    logic data_hazard;
    logic stall_inc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    assign dwait_cond = d_mem_req_mem && !d_mem_ready;

    // Register-match terms per stage; constant gates select the forwarding configuration
    assign rs_any  = use_rs | use_rs_at_id;
    assign ex_rs   = reg_write_ex  && (write_reg_ex  == rs_id);
    assign ex_rt   = reg_write_ex  && (write_reg_ex  == rt_id);
    assign mem_rs  = reg_write_mem && (write_reg_mem == rs_id);
    assign mem_rt  = reg_write_mem && (write_reg_mem == rt_id);
    assign wb_rs   = reg_write_wb  && (write_reg_wb  == rs_id);
    assign wb_rt   = reg_write_wb  && (write_reg_wb  == rt_id);

    assign raw_ex  = (NO_FWD & ((rs_any & ex_rs) | (use_rt & ex_rt))) | (use_rs_at_id & ex_rs);
    assign raw_mem = (NO_FWD & ((rs_any & mem_rs) | (use_rt & mem_rt))) | (use_rs_at_id & mem_rs);
    assign raw_wb  = NO_RFSF &
                     ((NO_FWD & ((rs_any & wb_rs) | (use_rt & wb_rt))) | (use_rs_at_id & wb_rs));

    assign lu_ex   = (use_rs | use_rt) & d_mem_read_ex & ((rs_id == rt_ex) | (rt_id == rt_ex));
    assign lu_mem  = NO_FWD & (use_rs | use_rt) & d_mem_read_mem &
                     ((rs_id == rt_mem) | (rt_id == rt_mem));
    assign lu_wb   = NO_RFSF & (use_rs | use_rt) & d_mem_read_wb &
                     ((rs_id == rt_wb) | (rt_id == rt_wb));

    assign data_hazard = raw_ex | raw_mem | raw_wb | lu_ex | lu_mem | lu_wb;

    // Next state, wait counter and pipeline control
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = '0;
        mem_timeout_d = mem_timeout_q;
        pc_write      = 1'b1;
        ir_write      = 1'b1;
        bubblify      = 1'b0;
        flush_if      = 1'b0;
        freeze        = 1'b0;

        if (halt_wb) begin
            state_d = S_HALT;
        end else begin
            case (state_q)
                S_RUN:   if (dwait_cond) state_d = S_DWAIT;
                S_DWAIT: if (d_mem_ready) state_d = S_RUN;
                S_HALT:  state_d = S_HALT;
                default: state_d = S_RUN;
            endcase
        end

        if (state_d == S_DWAIT) begin
            wait_cnt_d = (wait_cnt_q == WAIT_W'(MAX_WAIT)) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
            if (wait_cnt_d == WAIT_W'(MAX_WAIT)) mem_timeout_d = 1'b1;
        end

        if (reset) begin
            pc_write = 1'b0;
            ir_write = 1'b0;
            bubblify = 1'b1;
        end else if (state_q == S_HALT) begin
            pc_write = 1'b0;
            ir_write = 1'b0;
            bubblify = 1'b1;
            freeze   = 1'b1;
        end else if (dwait_cond) begin
            // branch_miss is deliberately ignored: the frozen branch re-presents after release
            pc_write = 1'b0;
            ir_write = 1'b0;
            freeze   = 1'b1;
        end else if (data_hazard) begin
            pc_write = 1'b0;
            ir_write = 1'b0;
            bubblify = 1'b1;
        end else begin
            if (is_jump_id) flush_if = 1'b1;
            if (branch_miss) begin
                bubblify = 1'b1;
                flush_if = 1'b1;
            end
        end
    end

    assign incr_num_inst = !(bubblify || flush_if || freeze) && (state_q == S_RUN) && !reset;
    assign stall_inc     = (freeze || (bubblify && !flush_if)) && (state_q != S_HALT);

    always_comb begin
        num_inst_d  = sat_inc(num_inst_q, incr_num_inst);
        num_stall_d = sat_inc(num_stall_q, stall_inc);
        num_flush_d = sat_inc(num_flush_q, flush_if && (state_q != S_HALT));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
            num_inst_q    <= '0;
            num_stall_q   <= '0;
            num_flush_q   <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            num_inst_q    <= num_inst_d;
            num_stall_q   <= num_stall_d;
            num_flush_q   <= num_flush_d;
        end
    end

    assign halted      = (state_q == S_HALT);
    assign mem_timeout = mem_timeout_q;
    assign num_inst    = num_inst_q;
    assign num_stall   = num_stall_q;
    assign num_flush   = num_flush_q;

endmodule
